// File: rtl/text_buffer_writer.sv
// text_buffer_writer: turns an ASCII stream into cursor-tracked text-buffer cell writes,
// handling LF/CR/BS/FF and clearing rows or the whole screen with spaces.
module text_buffer_writer #(
  parameter int COLS           = 80,
  parameter int ROWS           = 30,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [6:0] in_char,
  output logic       in_ready,
  output logic       wr_en,
  output logic [6:0] wr_x,
  output logic [4:0] wr_y,
  output logic [6:0] wr_char,
  output logic [6:0] cursor_x,
  output logic [4:0] cursor_y,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, CLEAR_ROW, CLEAR_ALL} state_t;
  localparam state_t     RST_STATE = CLEAR_ON_RESET ? CLEAR_ALL : IDLE;
  localparam logic [6:0] XMAX = 7'(COLS - 1);
  localparam logic [4:0] YMAX = 5'(ROWS - 1);
  localparam logic [6:0] SP = 7'h20, LF = 7'h0A, CR = 7'h0D, BS = 7'h08, FF = 7'h0C;
  state_t     state_q, state_d;
  logic [6:0] cnt_x_q, cnt_x_d, cursor_x_q, cursor_x_d, wr_x_q, wr_x_d, wr_char_q, wr_char_d;
  logic [4:0] cnt_y_q, cnt_y_d, cursor_y_q, cursor_y_d, wr_y_q, wr_y_d;
  logic       wr_en_q, wr_en_d;
  logic       idle, acc, prt, last_x, last_y, eol;
  logic [4:0] y_adv;
  assign idle   = state_q == IDLE;
  assign acc    = in_valid && idle;
  assign prt    = in_char >= 7'h20 && in_char != 7'h7F;
  assign last_x = cnt_x_q == XMAX;
  assign last_y = cnt_y_q == YMAX;
  assign eol    = cursor_x_q == XMAX;
  assign y_adv  = cursor_y_q == YMAX ? 5'd0 : cursor_y_q + 5'd1;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RST_STATE;
      cnt_x_q    <= '0;
      cnt_y_q    <= '0;
      cursor_x_q <= '0;
      cursor_y_q <= '0;
      wr_en_q    <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_char_q  <= SP;
    end else begin
      state_q    <= state_d;
      cnt_x_q    <= cnt_x_d;
      cnt_y_q    <= cnt_y_d;
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      wr_en_q    <= wr_en_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_char_q  <= wr_char_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (acc) state_d = (in_char == LF || (prt && eol)) ? CLEAR_ROW :
                                    in_char == FF ? CLEAR_ALL : IDLE;
      CLEAR_ROW: if (last_x) state_d = IDLE;
      CLEAR_ALL: if (last_x && last_y) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  // Clear counters sit at zero in IDLE so every clear starts from column/row 0.
  always_comb begin
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    cnt_x_d    = (idle || last_x) ? 7'd0 : cnt_x_q + 7'd1;
    cnt_y_d    = state_q != CLEAR_ALL ? 5'd0 : last_x ? (last_y ? 5'd0 : cnt_y_q + 5'd1) : cnt_y_q;
    wr_en_d    = !idle;
    wr_x_d     = idle ? wr_x_q : cnt_x_q;
    wr_y_d     = state_q == CLEAR_ALL ? cnt_y_q : state_q == CLEAR_ROW ? cursor_y_q : wr_y_q;
    wr_char_d  = idle ? wr_char_q : SP;
    if (acc) begin
      if (prt) begin
        wr_en_d    = 1'b1;
        wr_x_d     = cursor_x_q;
        wr_y_d     = cursor_y_q;
        wr_char_d  = in_char;
        cursor_x_d = eol ? 7'd0 : cursor_x_q + 7'd1;
        cursor_y_d = eol ? y_adv : cursor_y_q;
      end else if (in_char == LF) begin
        cursor_x_d = 7'd0;
        cursor_y_d = y_adv;
      end else if (in_char == CR) begin
        cursor_x_d = 7'd0;
      end else if (in_char == BS && cursor_x_q != 7'd0) begin
        cursor_x_d = cursor_x_q - 7'd1;
        wr_en_d    = 1'b1;
        wr_x_d     = cursor_x_q - 7'd1;
        wr_y_d     = cursor_y_q;
        wr_char_d  = SP;
      end else if (in_char == FF) begin
        cursor_x_d = 7'd0;
        cursor_y_d = 5'd0;
      end
    end
  end
  assign in_ready = reset && idle;
  assign busy     = !in_ready;
  assign wr_en    = wr_en_q;
  assign wr_x     = wr_x_q;
  assign wr_y     = wr_y_q;
  assign wr_char  = wr_char_q;
  assign cursor_x = cursor_x_q;
  assign cursor_y = cursor_y_q;
endmodule
